mem_to_dcache_bridge: RTL and testbench
=======================================

MEM_TO_DCACHE_BRIDGE -- requirements
Module: mem_to_dcache_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: MEM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: data width; byte-enable width is DATA_WIDTH/8.
REQ-003 SHALL have parameter INDEX_WIDTH, default 12: DCACHE index width, taken from address bits [INDEX_WIDTH-1:0].
REQ-004 SHALL have parameter TAG_WIDTH, default 20: DCACHE tag width, taken from address bits [INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH]; INDEX_WIDTH+TAG_WIDTH <= ADDR_WIDTH.
REQ-005 SHALL have parameter MAX_OUTSTANDING, default 4: maximum number of granted, not-yet-responded transactions; minimum 1.
REQ-006 Ports SHALL be as follows. One clock; reset is asynchronous and active-high.
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  asynchronous active-high reset.
- s_mem_req  in  1  MEM request.
- s_mem_gnt  out  1  MEM grant.
- s_mem_addr  in  ADDR_WIDTH  request address.
- s_mem_we  in  1  1 = write.
- s_mem_wdata  in  DATA_WIDTH  write data.
- s_mem_be  in  DATA_WIDTH/8  byte enables.
- s_mem_valid  out  1  response valid.
- s_mem_rdata  out  DATA_WIDTH  read data.
- dc_data_req_o  out  1  DCACHE request.
- dc_data_gnt_i  in  1  DCACHE grant.
- dc_address_index_o  out  INDEX_WIDTH  index.
- dc_address_tag_o  out  TAG_WIDTH  tag, qualified by tag_valid.
- dc_tag_valid_o  out  1  tag valid.
- dc_data_we_o, dc_data_wdata_o, dc_data_be_o  out  1/DATA_WIDTH/DATA_WIDTH/8  passthrough.
- dc_data_rvalid_i  in  1  read data valid.
- dc_data_rdata_i  in  DATA_WIDTH  read data.
- outstanding_o  out  clog2(MAX_OUTSTANDING+1)  current outstanding count.
- proto_err_o  out  1  sticky protocol-error flag.

Function
REQ-007 dc_data_req_o SHALL equal s_mem_req AND NOT full, where full means count == MAX_OUTSTANDING.
REQ-008 s_mem_gnt SHALL equal dc_data_gnt_i AND dc_data_req_o, combinationally; a handshake occurs when s_mem_gnt = 1.
REQ-009 Index, we, wdata and be SHALL pass through combinationally from the MEM inputs.
REQ-010 On a handshake, the tag stage SHALL capture the address tag; in the next cycle dc_tag_valid_o SHALL be 1 and dc_address_tag_o SHALL carry the registered tag.
REQ-011 Outside a tag cycle, dc_tag_valid_o SHALL be 0 and dc_address_tag_o SHALL hold its last value.
REQ-012 Back-to-back handshakes SHALL be supported, including a new grant in the same cycle as the previous tag cycle, giving one transaction per cycle.
REQ-013 An in-order response FIFO of depth MAX_OUTSTANDING SHALL record one type bit (read/write) per handshake.
REQ-014 Read response: when dc_data_rvalid_i = 1 and the FIFO head is a read, s_mem_valid SHALL be 1 and s_mem_rdata SHALL equal dc_data_rdata_i in the same cycle, and the head SHALL be popped.
REQ-015 Write response: when the head is a write and its tag cycle has already completed, s_mem_valid SHALL be 1 for exactly one cycle and the head SHALL be popped. Minimum write latency is handshake at cycle t, tag at t+1, response at t+2.
REQ-016 At most one response SHALL be issued per cycle.
REQ-017 s_mem_rdata SHALL be 0 on write responses.
REQ-018 A push and a pop in the same cycle SHALL leave the count unchanged; when full, a pop SHALL NOT enable a grant in the same cycle (grant is decided from the registered count).
REQ-019 dc_data_rvalid_i arriving with an empty FIFO, or with a write at the head, SHALL set proto_err_o; that rvalid SHALL be dropped, with no s_mem_valid and no pop.
REQ-020 outstanding_o SHALL equal the FIFO count; FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-021 An rvalid in the same cycle as a handshake whose type is read SHALL pop the old head before the new entry becomes visible.

Reset
REQ-022 While rst_i = 1, regardless of clock, these SHALL hold: count = 0, pointers = 0, tag stage invalid, dc_tag_valid_o = 0, dc_address_tag_o = 0, s_mem_valid = 0, proto_err_o = 0.
REQ-023 Reset mid-operation SHALL discard all outstanding entries; rvalids arriving after reset release with an empty FIFO SHALL set proto_err_o.
REQ-024 proto_err_o SHALL clear only on reset.

Verification
REQ-025 Single read: request to address 0x0000_3ABC, gnt at cycle 0 -> tag_valid at cycle 1 with tag 0x00003, index 0xABC; rvalid at cycle 3 with data 0xDEAD -> s_mem_valid at cycle 3 with rdata 0xDEAD.
REQ-026 Single write: gnt at cycle 0 -> tag_valid at cycle 1, s_mem_valid at cycle 2, outstanding_o returns 1 -> 0.
REQ-027 Full: 4 reads granted, none returned -> dc_data_req_o = 0 and s_mem_gnt = 0 with s_mem_req = 1; one rvalid -> grant permitted the following cycle.
REQ-028 Ordering: issue W, R, W back-to-back with rvalid at cycle 4 -> responses at cycles 2, 4 and 5, in order.
REQ-029 Error: rvalid with empty FIFO -> proto_err_o = 1, s_mem_valid = 0, and proto_err_o stays 1 until rst_i.
REQ-030 Reset: assert rst_i with 3 outstanding -> outstanding_o = 0 and dc_tag_valid_o = 0 immediately (asynchronously).

Source files
------------

// File: rtl/mem_to_dcache_bridge.sv
// Bridges a MEM-style request/grant port onto a DCACHE port with a split index/tag phase.
// Responses are returned in order from a small type FIFO; protocol violations set a sticky flag.
module mem_to_dcache_bridge #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int INDEX_WIDTH     = 12,
  parameter int TAG_WIDTH       = 20,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   s_mem_req,
  output logic                                   s_mem_gnt,
  input  logic [ADDR_WIDTH-1:0]                  s_mem_addr,
  input  logic                                   s_mem_we,
  input  logic [DATA_WIDTH-1:0]                  s_mem_wdata,
  input  logic [DATA_WIDTH/8-1:0]                s_mem_be,
  output logic                                   s_mem_valid,
  output logic [DATA_WIDTH-1:0]                  s_mem_rdata,
  output logic                                   dc_data_req_o,
  input  logic                                   dc_data_gnt_i,
  output logic [INDEX_WIDTH-1:0]                 dc_address_index_o,
  output logic [TAG_WIDTH-1:0]                   dc_address_tag_o,
  output logic                                   dc_tag_valid_o,
  output logic                                   dc_data_we_o,
  output logic [DATA_WIDTH-1:0]                  dc_data_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                dc_data_be_o,
  input  logic                                   dc_data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                  dc_data_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   proto_err_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [CNT_W-1:0]           count_q, count_d;
  logic [PTR_W-1:0]           wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0] type_q;
  logic                       tag_vld_q;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic                       proto_err_q, proto_err_d;

  logic full, push, head_vld, head_we, head_busy, wr_rsp, rd_rsp, pop, bad_rvalid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : p + 1'b1;
  endfunction

  assign full          = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign dc_data_req_o = s_mem_req & ~full;
  assign s_mem_gnt     = dc_data_gnt_i & dc_data_req_o;
  assign push          = s_mem_gnt;

  assign dc_address_index_o = s_mem_addr[INDEX_WIDTH-1:0];
  assign dc_data_we_o       = s_mem_we;
  assign dc_data_wdata_o    = s_mem_wdata;
  assign dc_data_be_o       = s_mem_be;
  assign dc_address_tag_o   = tag_q;
  assign dc_tag_valid_o     = tag_vld_q;

  // The newest entry is the one in the tag stage; a lone write head must wait for it to finish.
  assign head_vld   = (count_q != '0);
  assign head_we    = type_q[rptr_q];
  assign head_busy  = tag_vld_q && (count_q == CNT_W'(1));
  assign wr_rsp     = head_vld & head_we & ~head_busy;
  assign rd_rsp     = dc_data_rvalid_i & head_vld & ~head_we;
  assign pop        = wr_rsp | rd_rsp;
  assign bad_rvalid = dc_data_rvalid_i & ~(head_vld & ~head_we);

  assign s_mem_valid   = pop;
  assign s_mem_rdata   = rd_rsp ? dc_data_rdata_i : '0;
  assign outstanding_o = count_q;
  assign proto_err_o   = proto_err_q;

  assign count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
  assign proto_err_d = proto_err_q | bad_rvalid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q     <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      tag_vld_q   <= 1'b0;
      tag_q       <= '0;
      proto_err_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
      tag_vld_q   <= push;
      if (push) begin
        tag_q  <= s_mem_addr[INDEX_WIDTH+TAG_WIDTH-1:INDEX_WIDTH];
        wptr_q <= ptr_inc(wptr_q);
      end
      if (pop) rptr_q <= ptr_inc(rptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) type_q[wptr_q] <= s_mem_we;
  end

endmodule

// File: tb/tb_mem_to_dcache_bridge.sv
// Directed bench for mem_to_dcache_bridge with an in-order response scoreboard.
module tb_mem_to_dcache_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_mem_req, s_mem_gnt, s_mem_we, s_mem_valid;
  logic [31:0] s_mem_addr;
  logic [63:0] s_mem_wdata, s_mem_rdata;
  logic [7:0]  s_mem_be;
  logic        dc_data_req_o, dc_data_gnt_i, dc_tag_valid_o, dc_data_we_o;
  logic [11:0] dc_address_index_o;
  logic [19:0] dc_address_tag_o;
  logic [63:0] dc_data_wdata_o, dc_data_rdata_i;
  logic [7:0]  dc_data_be_o;
  logic        dc_data_rvalid_i;
  logic [2:0]  outstanding_o;
  logic        proto_err_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb_q[$];

  mem_to_dcache_bridge dut (
    .clk_i(clk), .rst_i(rst),
    .s_mem_req(s_mem_req), .s_mem_gnt(s_mem_gnt), .s_mem_addr(s_mem_addr),
    .s_mem_we(s_mem_we), .s_mem_wdata(s_mem_wdata), .s_mem_be(s_mem_be),
    .s_mem_valid(s_mem_valid), .s_mem_rdata(s_mem_rdata),
    .dc_data_req_o(dc_data_req_o), .dc_data_gnt_i(dc_data_gnt_i),
    .dc_address_index_o(dc_address_index_o), .dc_address_tag_o(dc_address_tag_o),
    .dc_tag_valid_o(dc_tag_valid_o), .dc_data_we_o(dc_data_we_o),
    .dc_data_wdata_o(dc_data_wdata_o), .dc_data_be_o(dc_data_be_o),
    .dc_data_rvalid_i(dc_data_rvalid_i), .dc_data_rdata_i(dc_data_rdata_i),
    .outstanding_o(outstanding_o), .proto_err_o(proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_mem_req = 0; s_mem_we = 0; s_mem_addr = '0; s_mem_wdata = '0; s_mem_be = '0;
    dc_data_rvalid_i = 0; dc_data_rdata_i = '0;
  endtask

  // Every response is matched in order against the scoreboard.
  always @(negedge clk) begin
    if (s_mem_valid) begin
      if (sb_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else chk("rsp_rdata", s_mem_rdata, sb_q.pop_front());
    end
  end

  initial begin
    idle();
    dc_data_gnt_i = 1;
    rst = 1;
    #3;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_tag_valid", dc_tag_valid_o, 0);
    chk("rst_tag", dc_address_tag_o, 0);
    chk("rst_valid", s_mem_valid, 0);
    chk("rst_proto_err", proto_err_o, 0);
    tick(); tick();
    rst = 0;

    // Single read
    s_mem_req = 1; s_mem_addr = 32'h0000_3ABC; s_mem_be = 8'hFF;
    sb_q.push_back(64'hDEAD);
    @(negedge clk);
    chk("rd_gnt", s_mem_gnt, 1);
    chk("rd_index", dc_address_index_o, 12'hABC);
    tick(); idle();
    @(negedge clk);
    chk("rd_tag_valid", dc_tag_valid_o, 1);
    chk("rd_tag", dc_address_tag_o, 20'h00003);
    chk("rd_outstanding", outstanding_o, 1);
    tick();
    @(negedge clk);
    chk("rd_tag_valid_off", dc_tag_valid_o, 0);
    chk("rd_tag_hold", dc_address_tag_o, 20'h00003);
    tick();
    dc_data_rvalid_i = 1; dc_data_rdata_i = 64'hDEAD;
    @(negedge clk);
    chk("rd_valid", s_mem_valid, 1);
    tick(); idle();
    @(negedge clk);
    chk("rd_outstanding_done", outstanding_o, 0);
    tick();

    // Single write
    s_mem_req = 1; s_mem_we = 1; s_mem_addr = 32'h0012_3456;
    s_mem_wdata = 64'hCAFE_F00D_1234_5678; s_mem_be = 8'h0F;
    sb_q.push_back(64'h0);
    @(negedge clk);
    chk("wr_gnt", s_mem_gnt, 1);
    chk("wr_we_pass", dc_data_we_o, 1);
    chk("wr_wdata_pass", dc_data_wdata_o, 64'hCAFE_F00D_1234_5678);
    chk("wr_be_pass", dc_data_be_o, 8'h0F);
    tick(); idle();
    @(negedge clk);
    chk("wr_tag_valid", dc_tag_valid_o, 1);
    chk("wr_tag", dc_address_tag_o, 20'h00123);
    chk("wr_valid_early", s_mem_valid, 0);
    chk("wr_outstanding", outstanding_o, 1);
    tick();
    @(negedge clk);
    chk("wr_valid", s_mem_valid, 1);
    tick();
    @(negedge clk);
    chk("wr_valid_once", s_mem_valid, 0);
    chk("wr_outstanding_done", outstanding_o, 0);
    tick();

    // Ordering W, R, W
    s_mem_req = 1; s_mem_we = 1; s_mem_addr = 32'h1000; sb_q.push_back(64'h0);
    @(negedge clk); chk("ord_c0_valid", s_mem_valid, 0);
    tick();
    s_mem_we = 0; s_mem_addr = 32'h2000; sb_q.push_back(64'h1234);
    @(negedge clk); chk("ord_c1_valid", s_mem_valid, 0);
    tick();
    s_mem_we = 1; s_mem_addr = 32'h3000; sb_q.push_back(64'h0);
    @(negedge clk); chk("ord_c2_valid", s_mem_valid, 1);
    tick(); idle();
    @(negedge clk);
    chk("ord_c3_valid", s_mem_valid, 0);
    chk("ord_c3_outstanding", outstanding_o, 2);
    tick();
    dc_data_rvalid_i = 1; dc_data_rdata_i = 64'h1234;
    @(negedge clk); chk("ord_c4_valid", s_mem_valid, 1);
    tick(); idle();
    @(negedge clk); chk("ord_c5_valid", s_mem_valid, 1);
    tick();
    @(negedge clk); chk("ord_c6_valid", s_mem_valid, 0);
    tick();

    // Full: four reads outstanding, then one rvalid frees a slot a cycle later
    for (int i = 0; i < 4; i++) begin
      s_mem_req = 1; s_mem_we = 0; s_mem_addr = 32'(i) << 12;
      sb_q.push_back(64'hF000 + 64'(i));
      @(negedge clk); chk("full_fill_gnt", s_mem_gnt, 1);
      tick();
    end
    @(negedge clk);
    chk("full_req_o", dc_data_req_o, 0);
    chk("full_gnt", s_mem_gnt, 0);
    chk("full_outstanding", outstanding_o, 4);
    tick();
    dc_data_rvalid_i = 1; dc_data_rdata_i = 64'hF000;
    @(negedge clk);
    chk("full_pop_gnt", s_mem_gnt, 0);
    chk("full_pop_valid", s_mem_valid, 1);
    tick();
    dc_data_rdata_i = 64'hF001; sb_q.push_back(64'hF004);
    @(negedge clk);
    chk("full_regnt", s_mem_gnt, 1);
    chk("full_regnt_outstanding", outstanding_o, 3);
    tick();
    s_mem_req = 0; dc_data_rdata_i = 64'hF002;
    @(negedge clk);
    chk("pushpop_outstanding", outstanding_o, 3);
    tick();
    dc_data_rdata_i = 64'hF003; tick();
    dc_data_rdata_i = 64'hF004; tick();
    idle();
    @(negedge clk);
    chk("full_drained", outstanding_o, 0);
    tick();

    // Stray rvalid with empty FIFO
    dc_data_rvalid_i = 1; dc_data_rdata_i = 64'hBAD;
    @(negedge clk);
    chk("err_no_valid", s_mem_valid, 0);
    tick(); idle();
    @(negedge clk);
    chk("err_set", proto_err_o, 1);
    chk("err_outstanding", outstanding_o, 0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("err_sticky", proto_err_o, 1);
    tick();
    rst = 1; #1;
    chk("err_cleared_by_rst", proto_err_o, 0);
    tick(); rst = 0;

    // Asynchronous reset with three reads outstanding
    for (int i = 0; i < 3; i++) begin
      s_mem_req = 1; s_mem_we = 0; s_mem_addr = 32'h5000 + 32'(i);
      sb_q.push_back(64'hEE00 + 64'(i));
      tick();
    end
    idle();
    chk("pre_rst_outstanding", outstanding_o, 3);
    chk("pre_rst_tag_valid", dc_tag_valid_o, 1);
    #1 rst = 1;
    sb_q.delete();
    #1;
    chk("async_rst_outstanding", outstanding_o, 0);
    chk("async_rst_tag_valid", dc_tag_valid_o, 0);
    chk("async_rst_tag", dc_address_tag_o, 0);
    tick(); rst = 0;
    dc_data_rvalid_i = 1; dc_data_rdata_i = 64'hEE00;
    @(negedge clk);
    chk("post_rst_no_valid", s_mem_valid, 0);
    tick(); idle();
    @(negedge clk);
    chk("post_rst_err", proto_err_o, 1);
    tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
